// File: rtl/traffic_pkg.sv
// Shared types and defaults for the four-way signal controller's detector front end.
package traffic_pkg;

   localparam int NUM_LANES_DEF       = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int WAIT_LIMIT_DEF      = 200;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      SERVE = 2'd2
   } lane_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lane_debounce.sv
// One lane of loop-sensor conditioning: 2-flop synchroniser, stability counter
// and the debounced presence register.
module lane_debounce
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic sense,
   output logic present
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          present_q;
   logic          present_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count consecutive samples disagreeing with the held level; any agreeing sample restarts it.
   always_comb begin
      cnt_d     = '0;
      present_d = present_q;
      if (sync2_q != present_q) begin
         if (cnt_q == CNT_LAST) begin
            present_d = ~present_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         present_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sense;
         sync2_q   <= sync1_q;
         present_q <= present_d;
         cnt_q     <= cnt_d;
      end
   end

   assign present = present_q;

endmodule

// File: rtl/lane_request_detector.sv
// Vehicle-detector front end: per-lane debounce, latched request FSM cleared by green feedback.
// Optional starvation flag per lane is built when STARVE_DETECT_EN is defined.
module lane_request_detector
   import traffic_pkg::*;
#(
   parameter int NUM_LANES       = NUM_LANES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int WAIT_LIMIT      = WAIT_LIMIT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_LANES-1:0] sense,
   input  logic [NUM_LANES-1:0] green,
   output logic [NUM_LANES-1:0] req,
   output logic [NUM_LANES-1:0] present,
   output logic [NUM_LANES-1:0] starve
);

   logic [NUM_LANES-1:0] present_w;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         lane_state_t state_q;
         logic        req_q;
         logic        serve_next;

         lane_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .sense  (sense[gi]),
            .present(present_w[gi])
         );

         // Green always wins from any legal state; the illegal encoding recovers to IDLE.
         assign serve_next = green[gi] && (state_q != lane_state_t'(2'd3));

         always_ff @(posedge clk) begin
            if (reset) begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end else begin
               case (state_q)
                  IDLE: begin
                     if (green[gi]) begin
                        state_q <= SERVE;
                        req_q   <= present_w[gi];
                     end else if (present_w[gi]) begin
                        state_q <= PEND;
                        req_q   <= 1'b1;
                     end else begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                     end
                  end
                  PEND: begin
                     if (green[gi]) begin
                        state_q <= SERVE;
                        req_q   <= present_w[gi];
                     end else begin
                        state_q <= PEND;
                        req_q   <= 1'b1;
                     end
                  end
                  SERVE: begin
                     if (green[gi]) begin
                        state_q <= SERVE;
                        req_q   <= present_w[gi];
                     end else if (present_w[gi]) begin
                        state_q <= PEND;
                        req_q   <= 1'b1;
                     end else begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                     end
                  end
                  default: begin
                     state_q <= IDLE;
                     req_q   <= 1'b0;
                  end
               endcase
            end
         end

         assign req[gi]     = req_q;
         assign present[gi] = present_w[gi];

`ifdef STARVE_DETECT_EN
         localparam int            WW       = $clog2(WAIT_LIMIT + 1);
         localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_LIMIT);

         logic [WW-1:0] wait_q;
         logic [WW-1:0] wait_d;
         logic          starve_q;

         // Saturating wait time, only meaningful while the request sits unanswered.
         always_comb begin
            wait_d = '0;
            if (state_q == PEND) begin
               wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               wait_q   <= '0;
               starve_q <= 1'b0;
            end else begin
               wait_q <= wait_d;
               if (serve_next) begin
                  starve_q <= 1'b0;
               end else if (wait_d == WAIT_MAX) begin
                  starve_q <= 1'b1;
               end
            end
         end

         assign starve[gi] = starve_q;
`else
         assign starve[gi] = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_lane_request_detector.sv
// Self-checking bench for lane_request_detector: directed scenarios plus random traffic
// against a window-based behavioural model.
module tb_lane_request_detector;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int WL = 10;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] sense = '0;
   logic [N-1:0] green = '0;
   logic [N-1:0] req;
   logic [N-1:0] present;
   logic [N-1:0] starve;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lane_request_detector #(
      .NUM_LANES      (N),
      .DEBOUNCE_CYCLES(D),
      .WAIT_LIMIT     (WL)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .sense  (sense),
      .green  (green),
      .req    (req),
      .present(present),
      .starve (starve)
   );

   // Reference model: present flips once the last D synced samples since the
   // previous flip all disagree with it; requests are a pending/serving pair of flags.
   logic [N-1:0] m_sync1 = '0;
   logic [N-1:0] m_s = '0;
   logic [N-1:0] m_present = '0;
   logic [N-1:0] m_req = '0;
   logic [N-1:0] m_starve = '0;
   logic [N-1:0] m_pending = '0;
   logic [N-1:0] m_serving = '0;
   int           m_wait [N];
   bit           m_hist [N][$];

   always @(posedge clk) begin
      logic [N-1:0] old_s;
      logic [N-1:0] old_p;
      bit           all_diff;
      bit           was_pend;
      if (reset) begin
         m_sync1 = '0; m_s = '0; m_present = '0; m_req = '0;
         m_starve = '0; m_pending = '0; m_serving = '0;
         for (int i = 0; i < N; i++) begin
            m_wait[i] = 0;
            m_hist[i].delete();
         end
      end else begin
         old_s   = m_s;
         old_p   = m_present;
         m_s     = m_sync1;
         m_sync1 = sense;
         for (int i = 0; i < N; i++) begin
            was_pend = m_pending[i] && !m_serving[i];
            if (m_serving[i]) begin
               if (!green[i]) begin
                  m_serving[i] = 1'b0;
                  m_pending[i] = old_p[i];
               end
            end else if (green[i]) begin
               m_serving[i] = 1'b1;
               m_pending[i] = 1'b0;
            end else if (old_p[i]) begin
               m_pending[i] = 1'b1;
            end
            m_req[i] = m_serving[i] ? old_p[i] : m_pending[i];
`ifdef STARVE_DETECT_EN
            if (was_pend) m_wait[i] = (m_wait[i] < WL) ? m_wait[i] + 1 : WL;
            else          m_wait[i] = 0;
            if (green[i])            m_starve[i] = 1'b0;
            else if (m_wait[i] == WL) m_starve[i] = 1'b1;
`else
            m_starve[i] = 1'b0;
            m_wait[i]   = was_pend ? 1 : 0;
`endif
            m_hist[i].push_back(old_s[i]);
            if (m_hist[i].size() > D) void'(m_hist[i].pop_front());
            all_diff = (m_hist[i].size() == D);
            for (int k = 0; k < m_hist[i].size(); k++)
               if (m_hist[i][k] == old_p[i]) all_diff = 1'b0;
            if (all_diff) begin
               m_present[i] = ~old_p[i];
               m_hist[i].delete();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; sense = '0; green = '0;
      tick(); tick();
      n_checks++;
      if ({req, present, starve} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got req=%b present=%b starve=%b expected all 0", req, present, starve);
      end
      reset = 1'b0; sense[0] = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         n_checks++;
         if (present[0] !== 1'(e >= 6)) begin
            n_errors++;
            $display("FAIL latency_present0 edge %0d: got %b expected %b", e, present[0], e >= 6);
         end
         n_checks++;
         if (req[0] !== 1'(e >= 7)) begin
            n_errors++;
            $display("FAIL latency_req0 edge %0d: got %b expected %b", e, req[0], e >= 7);
         end
         n_checks++;
         if ({req[3:1], present[3:1]} !== '0) begin
            n_errors++;
            $display("FAIL latency_others edge %0d: got req=%b present=%b expected 0", e, req, present);
         end
      end
      $display("reset/latency: lane 0 request after %0d edges", 3 + D);
   endtask

   task automatic test_glitch();
      sense[1] = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (c == 3) sense[1] = 1'b0;
         tick();
         n_checks++;
         if (present[1] !== 1'b0 || req[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_reject cycle %0d: got present1=%b req1=%b expected 0", c, present[1], req[1]);
         end
      end
      $display("glitch: 3-sample pulse on lane 1 rejected");
   endtask

   task automatic test_latch_serve();
      int guard = 0;
      sense[2] = 1'b1;
      while (req[2] !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      n_checks++;
      if (req[2] !== 1'b1) begin
         n_errors++;
         $display("FAIL latch_req2_timeout: got %b expected 1 within 20 cycles", req[2]);
      end
      sense[2] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_checks++;
         if (req[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL latch_hold cycle %0d: got req2=%b expected 1", c, req[2]);
         end
      end
      green[2] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++;
         if (req[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL serve_empty cycle %0d: got req2=%b expected 0", c, req[2]);
         end
      end
      green[2] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (req[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL after_green_idle cycle %0d: got req2=%b expected 0", c, req[2]);
         end
      end
      $display("latch/serve: lane 2 request held, cleared by green, idle afterwards");
   endtask

   task automatic test_extend();
      int guard = 0;
      sense[3] = 1'b1;
      while (req[3] !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      green[3] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_checks++;
         if (req[3] !== 1'b1) begin
            n_errors++;
            $display("FAIL extend_req3 cycle %0d: got %b expected 1", c, req[3]);
         end
      end
      green[3] = 1'b0;
      tick();
      n_checks++;
      if (req[3] !== 1'b1) begin
         n_errors++;
         $display("FAIL rearm_req3: got %b expected 1", req[3]);
      end
      $display("extend/re-arm: lane 3 request held during and after green");
   endtask

   task automatic test_reset_mid();
      green[0] = 1'b1;
      tick(); tick(); tick();
      sense[1] = 1'b1;
      tick(); tick(); tick(); tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({req, present, starve} !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_outputs: got req=%b present=%b starve=%b expected all 0", req, present, starve);
      end
      reset = 1'b0; green = '0; sense = 4'b0010;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_checks++;
         if (present[1] !== 1'(e >= 2 + D) || req[1] !== 1'(e >= 3 + D)) begin
            n_errors++;
            $display("FAIL reset_mid_latency edge %0d: got present1=%b req1=%b expected %b %b",
                     e, present[1], req[1], e >= 2 + D, e >= 3 + D);
         end
      end
      $display("reset mid-operation: lane 1 debounce restarted");
   endtask

   task automatic test_starve();
      int   guard = 0;
      logic exp_s;
      sense[0] = 1'b1;
      while (req[0] !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      n_checks++;
      if (req[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL starve_pend_timeout: got req0=%b expected 1", req[0]);
      end
      sense[0] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
`ifdef STARVE_DETECT_EN
         exp_s = (k >= WL);
`else
         exp_s = 1'b0;
`endif
         n_checks++;
         if (starve[0] !== exp_s) begin
            n_errors++;
            $display("FAIL starve_set pend+%0d: got %b expected %b", k, starve[0], exp_s);
         end
      end
      green[0] = 1'b1;
      tick();
      n_checks++;
      if (starve[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL starve_clear: got %b expected 0", starve[0]);
      end
      green[0] = 1'b0;
      $display("starve: lane 0 flag checked over %0d pending edges", 12);
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 5) == 0) sense[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 9) == 0) green[$urandom_range(0, N - 1)] ^= 1'b1;
         reset = ($urandom_range(0, 249) == 0);
         tick();
         n_checks++;
         if (req !== m_req || present !== m_present || starve !== m_starve) begin
            n_errors++;
            bad++;
            $display("FAIL random_model cycle %0d: got req=%b present=%b starve=%b expected %b %b %b",
                     c, req, present, starve, m_req, m_present, m_starve);
         end
      end
      reset = 1'b0;
      $display("random: 600 cycles compared, %0d deviations", bad);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_latch_serve();
      test_extend();
      sense[3] = 1'b0;
      test_reset_mid();
      test_starve();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
